// File: rtl/uart_pkg.sv
// Shared definitions for the UART receiver: FSM states, oversampling constants, default width.
package uart_pkg;

    localparam int OVERSAMPLE    = 16;
    localparam int MID_SAMPLE    = 7;
    localparam int DATA_BITS_DEF = 8;
    localparam int CNT_W         = $clog2(OVERSAMPLE);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK
    } uart_state_e;

endpackage

// File: rtl/uart_sync.sv
// Two-flop synchronizer for the asynchronous serial line; resets to the idle (high) level.
module uart_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;

    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 16x-oversampled UART receiver. Define UART_RX_PARITY_EN to add a parity bit
// between data and stop (PARITY_ODD selects odd sense); otherwise o_parity_err is 0.
module uart_rx
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = DATA_BITS_DEF,
    parameter int PARITY_ODD = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx_tick,
    input  logic                 i_rx,
    output logic [DATA_BITS-1:0] o_data,
    output logic                 o_valid,
    output logic                 o_frame_err,
    output logic                 o_parity_err,
    output logic                 o_busy
);

    localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(MID_SAMPLE);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);
    localparam logic [2:0]       IDX_LAST = 3'(DATA_BITS - 1);

    if (DATA_BITS < 5 || DATA_BITS > 8 || PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_cfg
        $error("uart_rx: DATA_BITS must be 5..8 and PARITY_ODD 0 or 1");
    end

    logic rx_s;

    uart_sync u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (i_rx),
        .q     (rx_s)
    );

    uart_state_e          state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [2:0]           idx_q, idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 ferr_q, ferr_d;
    logic                 last_tick;

`ifdef UART_RX_PARITY_EN
    localparam logic PAR_ODD = (PARITY_ODD != 0);
    logic par_bad_q, par_bad_d;
    logic perr_q, perr_d;
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        shift_d   = shift_q;
        data_d    = data_q;
        valid_d   = 1'b0;
        ferr_d    = 1'b0;
        last_tick = (cnt_q == CNT_LAST);
`ifdef UART_RX_PARITY_EN
        par_bad_d = par_bad_q;
        perr_d    = 1'b0;
`endif
        if (rx_tick) begin
            case (state_q)
                IDLE: begin
                    if (!rx_s) begin
                        state_d = START;
                        cnt_d   = '0;
                    end
                end
                START: begin
                    // A start bit that is gone by mid-bit was noise; drop it silently.
                    if (cnt_q == CNT_MID) begin
                        cnt_d   = '0;
                        idx_d   = '0;
                        state_d = rx_s ? IDLE : DATA;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                DATA: begin
                    if (last_tick) begin
                        cnt_d   = '0;
                        // LSB arrives first, so after DATA_BITS shifts it sits in bit 0.
                        shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
                        if (idx_q == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
                            state_d = PARITY;
`else
                            state_d = STOP;
`endif
                        end else begin
                            idx_d = idx_q + 3'd1;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (last_tick) begin
                        cnt_d     = '0;
                        par_bad_d = rx_s ^ (^shift_q) ^ PAR_ODD;
                        state_d   = STOP;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
`endif
                STOP: begin
                    if (last_tick) begin
                        cnt_d  = '0;
                        data_d = shift_q;
                        if (rx_s) begin
                            valid_d = 1'b1;
`ifdef UART_RX_PARITY_EN
                            perr_d  = par_bad_q;
`endif
                            state_d = IDLE;
                        end else begin
                            ferr_d  = 1'b1;
                            state_d = BREAK;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                BREAK: begin
                    // Holding here keeps a long low line from looking like new start bits.
                    if (rx_s) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad_q <= 1'b0;
            perr_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            ferr_q    <= ferr_d;
`ifdef UART_RX_PARITY_EN
            par_bad_q <= par_bad_d;
            perr_q    <= perr_d;
`endif
        end
    end

    assign o_data      = data_q;
    assign o_valid     = valid_q;
    assign o_frame_err = ferr_q;
    assign o_busy      = (state_q != IDLE);
`ifdef UART_RX_PARITY_EN
    assign o_parity_err = perr_q;
`else
    assign o_parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: frames driven bit by bit, expected words queued and popped on o_valid.
module tb_uart_rx;

    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          rx_tick;
    logic          i_rx;
    logic [DW-1:0] o_data;
    logic          o_valid;
    logic          o_frame_err;
    logic          o_parity_err;
    logic          o_busy;

    uart_rx #(.DATA_BITS(DW), .PARITY_ODD(0)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rx_tick      (rx_tick),
        .i_rx         (i_rx),
        .o_data       (o_data),
        .o_valid      (o_valid),
        .o_frame_err  (o_frame_err),
        .o_parity_err (o_parity_err),
        .o_busy       (o_busy)
    );

    always #10 clk = ~clk;

    typedef struct packed {
        logic [7:0] data;
        logic       perr;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   checks = 0;
    int   failures = 0;
    int   valid_cnt = 0;
    int   ferr_cnt = 0;
    int   perr_cnt = 0;
    int   exp_valid = 0;
    int   cyc = 0;
    int   div = 27;
    int   tc = 0;
    int   valid_cyc = 0;
    int   start_cyc = 0;
    int   lat;
    int   v_snap;
    int   f_snap;
    logic prev_valid = 1'b0;
    logic prev_ferr = 1'b0;
`ifdef UART_RX_PARITY_EN
    logic par_flip = 1'b0;
`endif

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // baud_gen stand-in: one-clk tick every div clocks
    initial begin
        rx_tick = 1'b0;
        forever begin
            @(negedge clk);
            tc++;
            if (tc >= div) tc = 0;
            rx_tick = (tc == 0);
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (o_valid) begin
                valid_cnt++;
                if (valid_cnt == 1) valid_cyc = cyc;
                chk("valid_expected", 32'(sb.size() != 0), 1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    chk("rx_data", 32'(o_data), 32'(e.data));
                    chk("parity_err", 32'(o_parity_err), 32'(e.perr));
                end
                chk("valid_one_cycle", 32'(prev_valid), 0);
                chk("valid_no_ferr", 32'(o_frame_err), 0);
            end
            if (o_frame_err) begin
                ferr_cnt++;
                chk("ferr_one_cycle", 32'(prev_ferr), 0);
            end
            if (o_parity_err) begin
                perr_cnt++;
                chk("perr_with_valid", 32'(o_valid), 1);
            end
            prev_valid = o_valid;
            prev_ferr  = o_frame_err;
        end
    end

    initial begin
        #(60000 * 20);
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic bit_time(input logic b);
        i_rx = b;
        repeat (16 * div) @(negedge clk);
    endtask

    task automatic idle_ticks(input int n);
        i_rx = 1'b1;
        repeat (n * div) @(negedge clk);
    endtask

    task automatic expect_rx(input logic [7:0] d, input logic perr);
        sb.push_back({d, perr});
        exp_valid++;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        bit_time(1'b0);
        for (int i = 0; i < DW; i++) bit_time(d[i]);
`ifdef UART_RX_PARITY_EN
        bit_time((^d) ^ par_flip);
`endif
        bit_time(stop);
    endtask

    initial begin
        i_rx  = 1'b1;
        rst_n = 1'b0;
        repeat (5) @(negedge clk);
        chk("rst_data",  32'(o_data), 0);
        chk("rst_valid", 32'(o_valid), 0);
        chk("rst_ferr",  32'(o_frame_err), 0);
        chk("rst_perr",  32'(o_parity_err), 0);
        chk("rst_busy",  32'(o_busy), 0);
        rst_n = 1'b1;
        idle_ticks(4);

        // 0xA5 at divisor 27
        expect_rx(8'hA5, 1'b0);
        start_cyc = cyc;
        send_frame(8'hA5, 1'b1);
        idle_ticks(16);
        lat = valid_cyc - start_cyc;
        chk("a5_valid_count", 32'(valid_cnt), 1);
        chk("a5_latency_in_range", 32'(lat >= 150 * 27 && lat <= 160 * 27), 1);
        chk("a5_busy_idle", 32'(o_busy), 0);

        div = 4;
        idle_ticks(10);

        // 4-tick glitch on the line
        i_rx = 1'b0;
        repeat (2 * div) @(negedge clk);
        chk("glitch_busy_high", 32'(o_busy), 1);
        repeat (2 * div) @(negedge clk);
        idle_ticks(40);
        chk("glitch_busy_low", 32'(o_busy), 0);
        chk("glitch_no_valid", 32'(valid_cnt), 1);
        chk("glitch_no_ferr", 32'(ferr_cnt), 0);
        chk("glitch_data_held", 32'(o_data), 32'h0A5);

        // 0x3C with low stop, line held low for three more frames
        send_frame(8'h3C, 1'b0);
        i_rx = 1'b0;
        repeat (3 * 10 * 16 * div) @(negedge clk);
        chk("break_busy", 32'(o_busy), 1);
        chk("break_one_ferr", 32'(ferr_cnt), 1);
        chk("break_no_valid", 32'(valid_cnt), 1);
        chk("break_data", 32'(o_data), 32'h03C);
        idle_ticks(4);
        chk("break_recover_idle", 32'(o_busy), 0);
        expect_rx(8'h55, 1'b0);
        send_frame(8'h55, 1'b1);
        idle_ticks(16);
        chk("recover_valid", 32'(valid_cnt), 2);
        chk("recover_ferr", 32'(ferr_cnt), 1);

        // back-to-back, no idle gap
        expect_rx(8'h00, 1'b0);
        expect_rx(8'hFF, 1'b0);
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        idle_ticks(32);
        chk("b2b_valid", 32'(valid_cnt), 4);
        chk("b2b_data_last", 32'(o_data), 32'h0FF);

`ifdef UART_RX_PARITY_EN
        par_flip = 1'b1;
        expect_rx(8'h5A, 1'b1);
        send_frame(8'h5A, 1'b1);
        par_flip = 1'b0;
        expect_rx(8'h5A, 1'b0);
        send_frame(8'h5A, 1'b1);
        idle_ticks(16);
        chk("parity_err_count", 32'(perr_cnt), 1);
`endif

        // reset pulse in the middle of bit 3
        v_snap = valid_cnt;
        f_snap = ferr_cnt;
        bit_time(1'b0);
        bit_time(1'b0);
        bit_time(1'b1);
        bit_time(1'b0);
        i_rx = 1'b0;
        repeat (8 * div) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_data",  32'(o_data), 0);
        chk("rst_mid_valid", 32'(o_valid), 0);
        chk("rst_mid_ferr",  32'(o_frame_err), 0);
        chk("rst_mid_perr",  32'(o_parity_err), 0);
        chk("rst_mid_busy",  32'(o_busy), 0);
        repeat (3) @(negedge clk);
        i_rx  = 1'b1;
        rst_n = 1'b1;
        idle_ticks(40);
        chk("rst_mid_no_valid", 32'(valid_cnt), 32'(v_snap));
        chk("rst_mid_no_ferr", 32'(ferr_cnt), 32'(f_snap));
        expect_rx(8'h81, 1'b0);
        send_frame(8'h81, 1'b1);
        idle_ticks(16);
        chk("post_rst_data", 32'(o_data), 32'h081);

        chk("valid_total", 32'(valid_cnt), 32'(exp_valid));
        chk("sb_drained", 32'(sb.size()), 0);
`ifndef UART_RX_PARITY_EN
        chk("perr_never", 32'(perr_cnt), 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
- REQ-001 SHALL have parameter DATA_BITS, default 8, number of data bits per frame; legal values 5..8.
- REQ-002 SHALL have parameter PARITY_ODD, default 0; 0 selects even parity, 1 selects odd parity; used only when UART_RX_PARITY_EN is defined.
- REQ-003 SHALL have port clk, input, 1 bit: the single system clock; all logic rising-edge.
- REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
- REQ-005 SHALL have port rx_tick, input, 1 bit: one-clk pulse at 16x baud, from baud_gen.
- REQ-006 SHALL have port i_rx, input, 1 bit: asynchronous serial line, idle high.
- REQ-007 SHALL have port o_data, output, DATA_BITS bits: last received word, LSB first on the wire.
- REQ-008 SHALL have port o_valid, output, 1 bit: one-clk pulse when o_data is updated by a good frame.
- REQ-009 SHALL have port o_frame_err, output, 1 bit: one-clk pulse when the stop bit is sampled low.
- REQ-010 SHALL have port o_parity_err, output, 1 bit: one-clk pulse, coincident with o_valid, on parity mismatch.
- REQ-011 SHALL have port o_busy, output, 1 bit: high in every state except IDLE.

Function
- REQ-012 SHALL pass i_rx through a 2-flop synchronizer; the FSM uses only the synchronized value.
- REQ-013 SHALL advance the sample counter and FSM only on clk edges where rx_tick=1.
- REQ-014 SHALL use FSM states IDLE, START, DATA, PARITY, STOP, BREAK.
- REQ-015 In IDLE, a tick with synchronized rx=0 SHALL enter START with tick counter=0.
- REQ-016 In START, at tick count 7 (mid-bit), rx=0 SHALL enter DATA with counter and bit index cleared; rx=1 SHALL return to IDLE (glitch reject) with no output pulse.
- REQ-017 In DATA, every 16th tick SHALL shift rx into bit[index]; after bit DATA_BITS-1, SHALL enter PARITY when enabled, otherwise STOP.
- REQ-018 In PARITY, the 16th tick SHALL sample the parity bit and compare it against the XOR of the data bits (inverted when PARITY_ODD=1).
- REQ-019 In STOP, on the 16th tick: rx=1 SHALL load o_data, pulse o_valid (plus o_parity_err on mismatch) and enter IDLE; rx=0 SHALL load o_data, pulse only o_frame_err and enter BREAK.
- REQ-020 BREAK SHALL wait for a tick with rx=1, then enter IDLE; a held-low line SHALL produce exactly one o_frame_err.
- REQ-021 Output pulses SHALL be registered: high for exactly the one clk cycle after the deciding tick edge.
- REQ-022 o_data SHALL hold its value until the next frame completes.
- REQ-023 The next frame's start bit SHALL be accepted on the first IDLE tick after stop; back-to-back frames SHALL not be lost.
- REQ-024 Divisor changes in baud_gen mid-frame SHALL need no special handling; the block only counts ticks.

Reset
- REQ-025 rst_n=0 SHALL immediately force: state IDLE; counters 0; o_data 0; o_valid, o_frame_err, o_parity_err and o_busy all 0; synchronizer flops 1.
- REQ-026 Reset asserted mid-frame SHALL discard the partial frame and produce no output pulse.

Configuration
- REQ-027 Macro UART_RX_PARITY_EN: when defined, the PARITY state and o_parity_err are active; when undefined, the PARITY state is not compiled in, frames are start+data+stop, and o_parity_err is tied to 0.

Structure
- REQ-028 Package uart_pkg SHALL hold the FSM state enum, OVERSAMPLE=16, MID_SAMPLE=7 and the default data width.
- REQ-029 Sub-module uart_sync (2-flop synchronizer, reset value 1) SHALL be instantiated for i_rx.

Verification
- REQ-030 Divisor 27 at 50 MHz, frame 0xA5 with stop=1 -> one o_valid pulse, o_data=0xA5, about 160*27 clk after the start edge.
- REQ-031 i_rx low for 4 ticks, then high -> no o_valid and no o_frame_err; o_busy drops back to 0.
- REQ-032 Frame 0x3C with stop=0, line held low for 3 frames -> exactly one o_frame_err; no o_valid; recovery once the line goes high.
- REQ-033 With UART_RX_PARITY_EN defined, PARITY_ODD=0, byte 0x5A with parity bit=1 -> o_valid and o_parity_err coincident; with parity bit=0 -> o_valid only.
- REQ-034 Back-to-back frames 0x00 then 0xFF with no idle gap -> two o_valid pulses carrying 0x00 and 0xFF.
- REQ-035 rst_n pulsed low during bit 3 of a frame -> all outputs 0 and no pulse; the next clean frame 0x81 is received correctly.
